// File: rtl/rv_iommu_ds_mem_pkg.sv
// ============================================================================
// Module : rv_iommu_ds_mem_pkg
// Brief  : Shared types for the IOMMU DS-bus memory responder: AXI encodings,
//          default channel structs, FSM state enums and the error merge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv_iommu_ds_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic        user;
  } ds_aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } ds_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } ds_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        user;
  } ds_ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } ds_r_chan_t;

  typedef struct packed {
    ds_aw_chan_t aw;
    logic        aw_valid;
    ds_w_chan_t  w;
    logic        w_valid;
    logic        b_ready;
    ds_ar_chan_t ar;
    logic        ar_valid;
    logic        r_ready;
  } ds_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    ds_b_chan_t b;
    logic       r_valid;
    ds_r_chan_t r;
  } ds_axi_rsp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_BURST
`ifdef RV_IOMMU_DS_MEM_LAT_EN
    , R_WAIT
`endif
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
`ifdef RV_IOMMU_DS_MEM_LAT_EN
    , W_WAIT
`endif
  } w_state_e;

  // DECERR outranks SLVERR, which outranks OKAY/EXOKAY.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_iommu_ds_mem_burst_addr.sv
// ============================================================================
// Module : rv_iommu_ds_mem_burst_addr
// Brief  : Next-beat address, window check and burst legality for one path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_iommu_ds_mem_burst_addr
  import rv_iommu_ds_mem_pkg::*;
#(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          MemWords  = 4096,
  parameter int unsigned          IdxWidth  = 12,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [1:0]           burst_i,
  output logic [AddrWidth-1:0] next_addr_o,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 in_range_o,
  output logic                 legal_o
);

  localparam int unsigned Bytes   = DataWidth / 8;
  localparam int unsigned OffBits = $clog2(Bytes);
  localparam logic [AddrWidth-1:0] WinBytes = AddrWidth'(MemWords) * AddrWidth'(Bytes);

  logic [AddrWidth-1:0] offset;

  assign offset      = addr_i - BaseAddr;
  assign in_range_o  = (addr_i >= BaseAddr) && (offset < WinBytes);
  assign idx_o       = IdxWidth'(offset >> OffBits);
  assign next_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + AddrWidth'(Bytes);
  assign legal_o     = (burst_i == BURST_FIXED) || (burst_i == BURST_INCR);

endmodule

`default_nettype wire

// File: rtl/rv_iommu_ds_mem_resp.sv
// ============================================================================
// Module : rv_iommu_ds_mem_resp
// Brief  : AXI4 memory responder for the IOMMU DS bus; independent read and
//          write FSMs. RV_IOMMU_DS_MEM_LAT_EN adds lat_i response wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv_iommu_ds_mem_resp
  import rv_iommu_ds_mem_pkg::*;
#(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          MemWords  = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = 64'h0,
  parameter type aw_chan_t = ds_aw_chan_t,
  parameter type w_chan_t  = ds_w_chan_t,
  parameter type b_chan_t  = ds_b_chan_t,
  parameter type ar_chan_t = ds_ar_chan_t,
  parameter type r_chan_t  = ds_r_chan_t,
  parameter type axi_req_t = ds_axi_req_t,
  parameter type axi_rsp_t = ds_axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
`ifdef RV_IOMMU_DS_MEM_LAT_EN
  input  logic [3:0] lat_i,
`endif
  input  axi_req_t ds_req_i,
  output axi_rsp_t ds_resp_o
);

  localparam int          Bytes    = DataWidth / 8;
  localparam int unsigned IdxWidth = (MemWords > 1) ? $clog2(MemWords) : 1;

  aw_chan_t aw_in;
  w_chan_t  w_in;
  ar_chan_t ar_in;
  r_chan_t  r_out;
  b_chan_t  b_out;
  assign aw_in = ds_req_i.aw;
  assign w_in  = ds_req_i.w;
  assign ar_in = ds_req_i.ar;

  logic unused_req;
  assign unused_req = ^{aw_in.size, aw_in.atop, aw_in.user, ar_in.size, ar_in.user, w_in.user};

  logic [DataWidth-1:0] mem_q [MemWords];

  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [AddrWidth-1:0] r_addr_q, r_addr_d, r_next_addr;
  logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]           r_burst_q, r_burst_d;
  logic                 ar_ready_q, ar_ready_d, r_valid, r_legal, r_in_range;
  logic [IdxWidth-1:0]  r_idx;

  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q, w_id_d;
  logic [AddrWidth-1:0] w_addr_q, w_addr_d, w_next_addr;
  logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]           w_burst_q, w_burst_d, w_err_q, w_err_d, w_beat_resp;
  logic                 aw_ready_q, aw_ready_d, w_ready, b_valid, w_legal, w_in_range, w_we;
  logic [IdxWidth-1:0]  w_idx;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
  logic [3:0]           r_wait_q, r_wait_d, w_wait_q, w_wait_d;
`endif

  rv_iommu_ds_mem_burst_addr #(
    .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MemWords(MemWords),
    .IdxWidth(IdxWidth), .BaseAddr(BaseAddr)
  ) u_rd_addr (
    .addr_i(r_addr_q), .burst_i(r_burst_q), .next_addr_o(r_next_addr),
    .idx_o(r_idx), .in_range_o(r_in_range), .legal_o(r_legal)
  );

  rv_iommu_ds_mem_burst_addr #(
    .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MemWords(MemWords),
    .IdxWidth(IdxWidth), .BaseAddr(BaseAddr)
  ) u_wr_addr (
    .addr_i(w_addr_q), .burst_i(w_burst_q), .next_addr_o(w_next_addr),
    .idx_o(w_idx), .in_range_o(w_in_range), .legal_o(w_legal)
  );

  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    r_valid    = 1'b0;
    ar_ready_d = 1'b0;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
    r_wait_d   = r_wait_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (ds_req_i.ar_valid && ar_ready_q) begin
          r_id_d    = ar_in.id;
          r_addr_d  = ar_in.addr;
          r_len_d   = ar_in.len;
          r_burst_d = ar_in.burst;
          r_cnt_d   = '0;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
          r_wait_d  = lat_i;
          r_state_d = (lat_i == 4'd0) ? R_BURST : R_WAIT;
`else
          r_state_d = R_BURST;
`endif
        end
      end
`ifdef RV_IOMMU_DS_MEM_LAT_EN
      R_WAIT: begin
        r_wait_d = r_wait_q - 4'd1;
        if (r_wait_q == 4'd1) r_state_d = R_BURST;
      end
`endif
      R_BURST: begin
        r_valid = 1'b1;
        if (ds_req_i.r_ready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_next_addr;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Registered ready: only high in cycles that start with the FSM idle.
    ar_ready_d = (r_state_d == R_IDLE);
  end

  assign w_we = (w_state_q == W_DATA) && ds_req_i.w_valid && w_legal && w_in_range;

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_burst_d   = w_burst_q;
    w_cnt_d     = w_cnt_q;
    w_err_d     = w_err_q;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    aw_ready_d  = 1'b0;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
    w_wait_d    = w_wait_q;
`endif
    w_beat_resp = !w_legal ? RESP_SLVERR : (!w_in_range ? RESP_DECERR : RESP_OKAY);
    if (w_in.last != (w_cnt_q == w_len_q)) w_beat_resp = resp_merge(w_beat_resp, RESP_SLVERR);
    case (w_state_q)
      W_IDLE: begin
        if (ds_req_i.aw_valid && aw_ready_q) begin
          w_id_d    = aw_in.id;
          w_addr_d  = aw_in.addr;
          w_len_d   = aw_in.len;
          w_burst_d = aw_in.burst;
          w_cnt_d   = '0;
          w_err_d   = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (ds_req_i.w_valid) begin
          w_err_d  = resp_merge(w_err_q, w_beat_resp);
          w_addr_d = w_next_addr;
          w_cnt_d  = (w_cnt_q == 8'hFF) ? w_cnt_q : w_cnt_q + 8'd1;
          if (w_in.last) begin
`ifdef RV_IOMMU_DS_MEM_LAT_EN
            w_wait_d  = lat_i;
            w_state_d = (lat_i == 4'd0) ? W_RESP : W_WAIT;
`else
            w_state_d = W_RESP;
`endif
          end
        end
      end
`ifdef RV_IOMMU_DS_MEM_LAT_EN
      W_WAIT: begin
        w_wait_d = w_wait_q - 4'd1;
        if (w_wait_q == 4'd1) w_state_d = W_RESP;
      end
`endif
      W_RESP: begin
        b_valid = 1'b1;
        if (ds_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      ar_ready_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_burst_q  <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= RESP_OKAY;
      aw_ready_q <= 1'b0;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
      r_wait_q   <= '0;
      w_wait_q   <= '0;
`endif
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_burst_q  <= w_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      aw_ready_q <= aw_ready_d;
`ifdef RV_IOMMU_DS_MEM_LAT_EN
      r_wait_q   <= r_wait_d;
      w_wait_q   <= w_wait_d;
`endif
    end
  end

  // Contents are never reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int i = 0; i < Bytes; i++) begin
        if (w_in.strb[i]) mem_q[w_idx][i*8 +: 8] <= w_in.data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    r_out = '0;
    b_out = '0;
    if (r_valid) begin
      r_out.id   = r_id_q;
      r_out.data = (r_legal && r_in_range) ? mem_q[r_idx] : '0;
      r_out.resp = !r_legal ? RESP_SLVERR : (!r_in_range ? RESP_DECERR : RESP_OKAY);
      r_out.last = (r_cnt_q == r_len_q);
    end
    if (b_valid) begin
      b_out.id   = w_id_q;
      b_out.resp = w_err_q;
    end
    ds_resp_o          = '0;
    ds_resp_o.ar_ready = ar_ready_q;
    ds_resp_o.aw_ready = aw_ready_q;
    ds_resp_o.w_ready  = w_ready;
    ds_resp_o.r_valid  = r_valid;
    ds_resp_o.r        = r_out;
    ds_resp_o.b_valid  = b_valid;
    ds_resp_o.b        = b_out;
  end

endmodule

`default_nettype wire
